// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the byte source and memory side use master.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        WE;
    logic [31:0] W_Addr;
    logic [31:0] W_Ins;

    modport master (output byte_valid, byte_data, input byte_ready, WE, W_Addr, W_Ins);
    modport slave  (input byte_valid, byte_data, output byte_ready, WE, W_Addr, W_Ins);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-framed byte stream -> MSB-first 32-bit words -> imem writes; holds core in reset.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMEM_WORDS = 64,
    parameter int CNT_W      = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [4:0]       flags;     // {byte_ready, cpu_rst, busy, done, err}
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      word;      // first three bytes; the fourth goes straight to W_Ins
    logic             xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       sum;
`endif

    function automatic logic [4:0] flags_of(state_t s);
        case (s)
            HDR, DATA, CHK: return 5'b11100;
            WRITE:          return 5'b01100;
            DONE:           return 5'b00010;
            ERR:            return 5'b01001;
            default:        return 5'b01000;
        endcase
    endfunction

    assign xfer           = bus.byte_valid & bus.byte_ready;
    assign bus.byte_ready = flags[4];
    assign cpu_rst        = flags[3];
    assign busy           = flags[2];
    assign done           = flags[1];
    assign err            = flags[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            flags      <= flags_of(IDLE);
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            bus.WE     <= 1'b0;
            bus.W_Addr <= '0;
            bus.W_Ins  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            bus.WE <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state <= HDR;
                    flags <= flags_of(HDR);
                end
                HDR: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum <= bus.byte_data;
`endif
                    if (bus.byte_data == 8'd0 || int'(bus.byte_data) > IMEM_WORDS) begin
                        state <= ERR;
                        flags <= flags_of(ERR);
                    end else begin
                        n_words  <= CNT_W'(bus.byte_data);
                        word_idx <= '0;
                        byte_cnt <= '0;
                        state    <= DATA;
                        flags    <= flags_of(DATA);
                    end
                end
                DATA: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum <= sum + bus.byte_data;
`endif
                    word     <= {word[15:0], bus.byte_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        // Write port is loaded here so WE/W_Addr/W_Ins appear together in WRITE.
                        bus.WE     <= 1'b1;
                        bus.W_Addr <= 32'({word_idx, 2'b00});
                        bus.W_Ins  <= {word, bus.byte_data};
                        state      <= WRITE;
                        flags      <= flags_of(WRITE);
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + ONE;
                    if (word_idx + ONE == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= CHK;
                        flags <= flags_of(CHK);
`else
                        state <= DONE;
                        flags <= flags_of(DONE);
`endif
                    end else begin
                        state <= DATA;
                        flags <= flags_of(DATA);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    if (8'(sum + bus.byte_data) == 8'd0) begin
                        state <= DONE;
                        flags <= flags_of(DONE);
                    end else begin
                        state <= ERR;
                        flags <= flags_of(ERR);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    flags <= flags_of(IDLE);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for framed loads plus hand sequences
// for stalls, bad headers, mid-load reset and (when enabled) the checksum byte.
module tb_imem_loader;
    localparam int IMEM_WORDS = 64;
    // expected {byte_ready, cpu_rst, busy, done, err}
    localparam logic [4:0] E_LOAD = 5'b11100;
    localparam logic [4:0] E_WR   = 5'b01100;
    localparam logic [4:0] E_DONE = 5'b00010;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic cpu_rst, busy, done, err;
    int   checks = 0;
    int   errors = 0;

    imem_loader_if bus ();

    imem_loader #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .bus(bus),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic [4:0]  fl;
        logic        we;
        logic [31:0] addr;
        logic [31:0] ins;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_ins[$];

    always @(negedge CLK) begin
        if (bus.WE) begin
            wq_addr.push_back(bus.W_Addr);
            wq_ins.push_back(bus.W_Ins);
        end
    end

    function automatic void add(input logic s, input logic v, input logic [7:0] d,
                                input logic [4:0] fl, input logic we,
                                input logic [31:0] addr, input logic [31:0] ins);
        vec_t e;
        e.s = s; e.v = v; e.d = d; e.fl = fl; e.we = we; e.addr = addr; e.ins = ins;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input logic s, input logic v, input logic [7:0] d);
        start = s;
        bus.byte_valid = v;
        bus.byte_data = d;
        @(posedge CLK);
        #1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.byte_ready, cpu_rst, busy, done, err};
    endfunction

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // T1: single word; T5: two words with ignored start pulses and a byte offered in WRITE
        add(1, 0, 8'h00, E_LOAD, 0, 32'h0, 32'h0);
        add(0, 1, 8'h01, E_LOAD, 0, 32'h0, 32'h0);
        add(0, 1, 8'h3C, E_LOAD, 0, 32'h0, 32'h0);
        add(0, 1, 8'h01, E_LOAD, 0, 32'h0, 32'h0);
        add(0, 1, 8'h00, E_LOAD, 0, 32'h0, 32'h0);
        add(0, 1, 8'h01, E_WR,   1, 32'h0, 32'h3C010001);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add(0, 0, 8'h00, E_LOAD, 0, 32'h0, 32'h3C010001);
        add(0, 1, 8'hC1, E_DONE, 0, 32'h0, 32'h3C010001);
`else
        add(0, 0, 8'h00, E_DONE, 0, 32'h0, 32'h3C010001);
`endif
        add(0, 0, 8'h00, E_DONE, 0, 32'h0, 32'h3C010001);
        add(1, 0, 8'h00, E_LOAD, 0, 32'h0, 32'h3C010001);
        add(0, 1, 8'h02, E_LOAD, 0, 32'h0, 32'h3C010001);
        add(1, 1, 8'hAA, E_LOAD, 0, 32'h0, 32'h3C010001);
        add(0, 1, 8'hBB, E_LOAD, 0, 32'h0, 32'h3C010001);
        add(0, 1, 8'hCC, E_LOAD, 0, 32'h0, 32'h3C010001);
        add(0, 1, 8'hDD, E_WR,   1, 32'h0, 32'hAABBCCDD);
        add(1, 1, 8'h11, E_LOAD, 0, 32'h0, 32'hAABBCCDD);
        add(1, 1, 8'h11, E_LOAD, 0, 32'h0, 32'hAABBCCDD);
        add(0, 1, 8'h22, E_LOAD, 0, 32'h0, 32'hAABBCCDD);
        add(0, 1, 8'h33, E_LOAD, 0, 32'h0, 32'hAABBCCDD);
        add(0, 1, 8'h44, E_WR,   1, 32'h4, 32'h11223344);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add(0, 0, 8'h00, E_LOAD, 0, 32'h4, 32'h11223344);
        add(0, 1, 8'h46, E_DONE, 0, 32'h4, 32'h11223344);
`else
        add(0, 0, 8'h00, E_DONE, 0, 32'h4, 32'h11223344);
`endif

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_flags", 32'(flags_now()), 32'(5'b01000));
        chk("rst_we", 32'(bus.WE), 32'h0);
        chk("rst_addr", bus.W_Addr, 32'h0);
        chk("rst_ins", bus.W_Ins, 32'h0);
        RST = 1'b0;
        apply(0, 1, 8'h05);
        chk("idle_no_consume", 32'(flags_now()), 32'(5'b01000));

        foreach (tbl[i]) begin
            apply(tbl[i].s, tbl[i].v, tbl[i].d);
            chk($sformatf("v%0d_flags", i), 32'(flags_now()), 32'(tbl[i].fl));
            chk($sformatf("v%0d_we", i), 32'(bus.WE), 32'(tbl[i].we));
            chk($sformatf("v%0d_addr", i), bus.W_Addr, tbl[i].addr);
            chk($sformatf("v%0d_ins", i), bus.W_Ins, tbl[i].ins);
        end

        // T2: N=3 with byte_valid toggling every cycle
        wq_addr.delete(); wq_ins.delete();
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h03);
        for (int i = 0; i < 12; i++) begin
            apply(0, 1, 8'(i));
            apply(0, 0, 8'h00);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        apply(0, 1, 8'hBB);
`endif
        apply(0, 0, 8'h00);
        apply(0, 0, 8'h00);
        chk("t2_we_count", 32'(wq_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wq_addr.size()) begin
                chk($sformatf("t2_addr%0d", i), wq_addr[i], 32'(4 * i));
                chk($sformatf("t2_ins%0d", i), wq_ins[i],
                    {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
            end
        end
        chk("t2_done", 32'(flags_now()), 32'(E_DONE));

        // T3: zero and oversize headers, then the largest legal header
        wq_addr.delete(); wq_ins.delete();
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h00);
        chk("t3_zero_err", 32'(flags_now()), 32'(5'b01001));
        apply(0, 1, 8'h05);
        chk("t3_err_holds", 32'(flags_now()), 32'(5'b01001));
        apply(1, 0, 8'h00);
        chk("t3_start_clears", 32'(flags_now()), 32'(E_LOAD));
        apply(0, 1, 8'(IMEM_WORDS + 1));
        chk("t3_big_err", 32'(flags_now()), 32'(5'b01001));
        chk("t3_no_we", 32'(wq_addr.size()), 32'd0);
        apply(1, 0, 8'h00);
        apply(0, 1, 8'(IMEM_WORDS));
        chk("t3_max_ok", 32'(flags_now()), 32'(E_LOAD));

        // T4: reset two bytes into word 1
        apply(0, 1, 8'h01); apply(0, 1, 8'h02); apply(0, 1, 8'h03); apply(0, 1, 8'h04);
        apply(0, 0, 8'h00);
        apply(0, 1, 8'h05); apply(0, 1, 8'h06);
        RST = 1'b1;
        #1;
        chk("t4_rst_flags", 32'(flags_now()), 32'(5'b01000));
        chk("t4_rst_addr", bus.W_Addr, 32'h0);
        apply(0, 0, 8'h00);
        RST = 1'b0;
        apply(0, 1, 8'h07);
        chk("t4_we_count", 32'(wq_addr.size()), 32'd1);
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h01);
        apply(0, 1, 8'hDE); apply(0, 1, 8'hAD); apply(0, 1, 8'hBE); apply(0, 1, 8'hEF);
        chk("t4_we", 32'(bus.WE), 32'h1);
        chk("t4_addr", bus.W_Addr, 32'h0);
        chk("t4_ins", bus.W_Ins, 32'hDEADBEEF);
        apply(0, 0, 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        apply(0, 1, 8'hC7);
`endif
        chk("t4_done", 32'(flags_now()), 32'(E_DONE));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // T6: good and bad checksum on a one-word image
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h01); apply(0, 1, 8'h00); apply(0, 1, 8'h00); apply(0, 1, 8'h00);
        apply(0, 1, 8'h01);
        apply(0, 0, 8'h00);
        chk("t6_chk_state", 32'(flags_now()), 32'(E_LOAD));
        apply(0, 1, 8'hFE);
        chk("t6_good", 32'(flags_now()), 32'(E_DONE));
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h01); apply(0, 1, 8'h00); apply(0, 1, 8'h00); apply(0, 1, 8'h00);
        apply(0, 1, 8'h01);
        apply(0, 0, 8'h00);
        apply(0, 1, 8'hFF);
        chk("t6_bad", 32'(flags_now()), 32'(5'b01001));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
